// File: rtl/iter_mult.sv
// Iterative radix-2 shift-add multiplier with optional signed operands and MAC mode.
// One multiplier bit per cycle; the product register updates only when the result is final.
module iter_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               sm_r;
  logic               last;

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so its partial product is subtracted.
  always_comb begin
    pp      = b_sh[0] ? a_sh : '0;
    acc_nxt = (last && sm_r) ? (acc - pp) : (acc + pp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      product <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sm_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
            b_sh  <= b;
            sm_r  <= signed_mode;
            acc   <= acc_en ? product : '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (last) begin
            product <= acc_nxt;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mult.sv
// Directed self-checking bench for iter_mult at WIDTH=8.
module tb_iter_mult;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               acc_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  iter_mult #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .acc_en     (acc_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE, check latency/busy, optionally stall in DONE, then retire it.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input logic ae, input logic [15:0] exp,
                        input int unsigned hold);
    int unsigned edges;
    logic        busy_ok;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    a = av; b = bv; signed_mode = sm; acc_en = ae; in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~av; b = ~bv;
    while (!out_valid && edges < 30) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, edges, 32'd9);
    check_eq({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    check_eq({tag, "_product"}, {16'b0, product}, {16'b0, exp});
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = ~in_valid; a = a + 8'h11; b = b ^ 8'h5A;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_hold_product"}, {16'b0, product}, {16'b0, exp});
      check_eq({tag, "_hold_valid"}, {30'b0, in_ready, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_retire"}, {29'b0, in_ready, out_valid, busy}, 32'b100);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned seen;
    int unsigned last_cyc;
    logic [15:0] exp_q [3];
    logic [7:0]  a_q [3];
    logic [7:0]  b_q [3];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; acc_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset_state", {15'b0, product, out_valid, busy, in_ready}, 32'b1);

    run_op("u_ffff",   8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 0);
    run_op("s_min_min", 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 0);
    run_op("s_m1_1",   8'hFF, 8'h01, 1'b1, 1'b0, 16'hFFFF, 0);
    run_op("u_ff_1",   8'hFF, 8'h01, 1'b0, 1'b0, 16'h00FF, 0);
    run_op("s_0_min",  8'h00, 8'h80, 1'b1, 1'b0, 16'h0000, 0);
    run_op("s_max_min", 8'h7F, 8'h80, 1'b1, 1'b0, 16'hC080, 0);
    run_op("mac_3x4",  8'h03, 8'h04, 1'b0, 1'b0, 16'h000C, 0);
    run_op("mac_5x6",  8'h05, 8'h06, 1'b0, 1'b1, 16'h002A, 0);
    run_op("mac_ff0",  8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 0);
    run_op("mac_wrap", 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFC02, 0);
    run_op("bp",       8'h12, 8'h34, 1'b0, 1'b0, 16'h03A8, 5);

    // Abort on the third CALC cycle.
    @(negedge clk);
    a = 8'h0B; b = 8'h0D; signed_mode = 1'b0; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("rst_mid_state", {15'b0, product, out_valid, busy, in_ready}, 32'b1);
    run_op("rst_mac_7x9", 8'h07, 8'h09, 1'b0, 1'b1, 16'h003F, 0);

    // Back-to-back: in_valid and out_ready held high; operands advance during DONE.
    a_q[0] = 8'h02; b_q[0] = 8'h03; exp_q[0] = 16'h0006;
    a_q[1] = 8'hFF; b_q[1] = 8'h02; exp_q[1] = 16'h01FE;
    a_q[2] = 8'h10; b_q[2] = 8'h10; exp_q[2] = 16'h0100;
    @(negedge clk);
    a = a_q[0]; b = b_q[0]; signed_mode = 1'b0; acc_en = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    seen = 0; last_cyc = 0; cyc = 0;
    while (seen < 3 && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid) begin
        check_eq("b2b_product", {16'b0, product}, {16'b0, exp_q[seen]});
        if (seen > 0) check_eq("b2b_period", cyc - last_cyc, WIDTH + 2);
        last_cyc = cyc;
        seen++;
        if (seen < 3) begin a = a_q[seen]; b = b_q[seen]; end
      end
    end
    check_eq("b2b_count", seen, 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
